// File: rtl/datapath_pkg.sv
// Shared constants for the single-bus datapath: widths, ALU opcodes, bus sources.
package datapath_pkg;

    localparam int DATA_W = 32;
    localparam int Z_W    = 2 * DATA_W;
    localparam int NREGS  = 16;

    // ALU operation encodings
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    // Bus source index: 0..15 are R0..R15, the rest are the special sources
    typedef logic [4:0] bus_src_t;
    localparam bus_src_t SRC_HI   = 5'd16;
    localparam bus_src_t SRC_LO   = 5'd17;
    localparam bus_src_t SRC_ZHI  = 5'd18;
    localparam bus_src_t SRC_ZLO  = 5'd19;
    localparam bus_src_t SRC_PC   = 5'd20;
    localparam bus_src_t SRC_MDR  = 5'd21;
    localparam bus_src_t SRC_C    = 5'd22;
    localparam bus_src_t SRC_NONE = 5'd23;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A comes from Y, B from the bus; double-width result feeds Z.
import datapath_pkg::*;

module alu #(
    parameter int WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic [4:0]         i_opcode,
    output logic [2*WIDTH-1:0] o_result
);
    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0]     w_sh;
    logic [2*WIDTH-1:0] w_rotr;
    logic [2*WIDTH-1:0] w_rotl;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_ua;
    logic [WIDTH-1:0]   w_ub;
    logic [WIDTH-1:0]   w_uq;
    logic [WIDTH-1:0]   w_ur;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    // Shift/rotate amount uses only the low bits of B; rotates via a doubled word.
    // Division works on magnitudes so no signed-overflow case (MIN / -1) exists.
    always_comb begin
        w_sh   = i_b[SHW-1:0];
        w_rotr = {i_a, i_a} >> w_sh;
        w_rotl = {i_a, i_a} << w_sh;
        w_prod = {{WIDTH{i_a[WIDTH-1]}}, i_a} * {{WIDTH{i_b[WIDTH-1]}}, i_b};
        w_ua   = i_a[WIDTH-1] ? -i_a : i_a;
        w_ub   = i_b[WIDTH-1] ? -i_b : i_b;
        w_uq   = w_ua / w_ub;
        w_ur   = w_ua % w_ub;
        if (w_ub == '0) begin
            w_quo = '1;
            w_rem = i_a;
        end else begin
            w_quo = (i_a[WIDTH-1] ^ i_b[WIDTH-1]) ? -w_uq : w_uq;
            w_rem = i_a[WIDTH-1] ? -w_ur : w_ur;
        end
    end

    // Operation select; single-width results land in the low half, high half zero.
    always_comb begin
        o_result = {{WIDTH{1'b0}}, i_b};
        case (i_opcode)
            OP_ADD:  o_result = {{WIDTH{1'b0}}, i_a + i_b};
            OP_SUB:  o_result = {{WIDTH{1'b0}}, i_a - i_b};
            OP_AND:  o_result = {{WIDTH{1'b0}}, i_a & i_b};
            OP_OR:   o_result = {{WIDTH{1'b0}}, i_a | i_b};
            OP_SHR:  o_result = {{WIDTH{1'b0}}, i_a >> w_sh};
            OP_SHRA: o_result = {{WIDTH{1'b0}}, $signed(i_a) >>> w_sh};
            OP_SHL:  o_result = {{WIDTH{1'b0}}, i_a << w_sh};
            OP_ROR:  o_result = {{WIDTH{1'b0}}, w_rotr[WIDTH-1:0]};
            OP_ROL:  o_result = {{WIDTH{1'b0}}, w_rotl[2*WIDTH-1:WIDTH]};
            OP_MUL:  o_result = w_prod;
            OP_DIV:  o_result = {w_rem, w_quo};
            OP_NEG:  o_result = {{WIDTH{1'b0}}, -i_b};
            OP_NOT:  o_result = {{WIDTH{1'b0}}, ~i_b};
            default: o_result = {{WIDTH{1'b0}}, i_b};
        endcase
    end

endmodule

// File: rtl/datapath.sv
// Single-bus CPU datapath: register file, special registers, bus mux and ALU.
// Internal state is mirrored on o_* debug outputs for observation.
import datapath_pkg::*;

module datapath #(
    parameter int WIDTH = DATA_W
) (
    input  logic               clock,
    input  logic               clear,
    input  logic [WIDTH-1:0]   Mdatain,
    input  logic               Read,
    input  logic               IncPC,
    input  logic [15:0]        Rin,
    input  logic [15:0]        Rout,
    input  logic               PCin,
    input  logic               Zin,
    input  logic               MDRin,
    input  logic               MARin,
    input  logic               Yin,
    input  logic               HIin,
    input  logic               LOin,
    input  logic               IRin,
    input  logic               PCout,
    input  logic               Zhighout,
    input  logic               Zlowout,
    input  logic               HIout,
    input  logic               LOout,
    input  logic               MDRout,
    input  logic               Cout,
    input  logic [4:0]         opcode,
    output logic [WIDTH-1:0]   o_bus,
    output logic [WIDTH-1:0]   o_pc,
    output logic [WIDTH-1:0]   o_ir,
    output logic [WIDTH-1:0]   o_mar,
    output logic [WIDTH-1:0]   o_mdr,
    output logic [WIDTH-1:0]   o_y,
    output logic [2*WIDTH-1:0] o_z,
    output logic [WIDTH-1:0]   o_hi,
    output logic [WIDTH-1:0]   o_lo
);
    logic [WIDTH-1:0]   r_regs [NREGS];
    logic [WIDTH-1:0]   r_pc, r_ir, r_mar, r_mdr, r_y, r_hi, r_lo;
    logic [2*WIDTH-1:0] r_z;

    bus_src_t           w_src;
    logic [WIDTH-1:0]   w_bus;
    logic [WIDTH-1:0]   w_cext;
    logic [2*WIDTH-1:0] w_alu;

    assign w_cext = {{(WIDTH-19){r_ir[18]}}, r_ir[18:0]};

    // Priority encode the drive selects; later assignments override, so the
    // lowest-priority source is written first and R0 last.
    always_comb begin
        w_src = SRC_NONE;
        if (Cout)     w_src = SRC_C;
        if (MDRout)   w_src = SRC_MDR;
        if (PCout)    w_src = SRC_PC;
        if (Zlowout)  w_src = SRC_ZLO;
        if (Zhighout) w_src = SRC_ZHI;
        if (LOout)    w_src = SRC_LO;
        if (HIout)    w_src = SRC_HI;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (Rout[i]) w_src = 5'(i);
        end
    end

    // Bus multiplexer driven by the encoded source; nothing selected reads 0.
    always_comb begin
        w_bus = '0;
        if (w_src < SRC_HI) begin
            w_bus = r_regs[w_src[3:0]];
        end else begin
            case (w_src)
                SRC_HI:  w_bus = r_hi;
                SRC_LO:  w_bus = r_lo;
                SRC_ZHI: w_bus = r_z[2*WIDTH-1:WIDTH];
                SRC_ZLO: w_bus = r_z[WIDTH-1:0];
                SRC_PC:  w_bus = r_pc;
                SRC_MDR: w_bus = r_mdr;
                SRC_C:   w_bus = w_cext;
                default: w_bus = '0;
            endcase
        end
    end

    alu #(.WIDTH(WIDTH)) u_alu (
        .i_a      (r_y),
        .i_b      (w_bus),
        .i_opcode (opcode),
        .o_result (w_alu)
    );

    // General-purpose register file loads from the bus per enable bit.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (Rin[i]) r_regs[i] <= w_bus;
            end
        end
    end

    // Special registers; a register driving the bus while loading sees its old value.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_pc  <= '0;
            r_ir  <= '0;
            r_mar <= '0;
            r_mdr <= '0;
            r_y   <= '0;
            r_z   <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            if (PCin)  r_pc  <= IncPC ? r_pc + 1'b1 : w_bus;
            if (IRin)  r_ir  <= w_bus;
            if (MARin) r_mar <= w_bus;
            if (MDRin) r_mdr <= Read ? Mdatain : w_bus;
            if (Yin)   r_y   <= w_bus;
            if (Zin)   r_z   <= w_alu;
            if (HIin)  r_hi  <= w_bus;
            if (LOin)  r_lo  <= w_bus;
        end
    end

    assign o_bus = w_bus;
    assign o_pc  = r_pc;
    assign o_ir  = r_ir;
    assign o_mar = r_mar;
    assign o_mdr = r_mdr;
    assign o_y   = r_y;
    assign o_z   = r_z;
    assign o_hi  = r_hi;
    assign o_lo  = r_lo;

endmodule

// File: tb/tb_datapath.sv
// Directed bench for the datapath: register transfers, ALU ops, bus priority, reset.
module tb_datapath;
  import datapath_pkg::*;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] Mdatain;
  logic        Read, IncPC;
  logic [15:0] Rin, Rout;
  logic        PCin, Zin, MDRin, MARin, Yin, HIin, LOin, IRin;
  logic        PCout, Zhighout, Zlowout, HIout, LOout, MDRout, Cout;
  logic [4:0]  opcode;
  logic [31:0] o_bus, o_pc, o_ir, o_mar, o_mdr, o_y, o_hi, o_lo;
  logic [63:0] o_z;

  int n_total = 0;
  int n_bad   = 0;

  datapath dut (
    .clock(clock), .clear(clear), .Mdatain(Mdatain), .Read(Read), .IncPC(IncPC),
    .Rin(Rin), .Rout(Rout), .PCin(PCin), .Zin(Zin), .MDRin(MDRin), .MARin(MARin),
    .Yin(Yin), .HIin(HIin), .LOin(LOin), .IRin(IRin), .PCout(PCout),
    .Zhighout(Zhighout), .Zlowout(Zlowout), .HIout(HIout), .LOout(LOout),
    .MDRout(MDRout), .Cout(Cout), .opcode(opcode),
    .o_bus(o_bus), .o_pc(o_pc), .o_ir(o_ir), .o_mar(o_mar), .o_mdr(o_mdr),
    .o_y(o_y), .o_z(o_z), .o_hi(o_hi), .o_lo(o_lo)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic idle();
    Mdatain = '0; Read = 0; IncPC = 0; Rin = '0; Rout = '0;
    PCin = 0; Zin = 0; MDRin = 0; MARin = 0; Yin = 0; HIin = 0; LOin = 0; IRin = 0;
    PCout = 0; Zhighout = 0; Zlowout = 0; HIout = 0; LOout = 0; MDRout = 0; Cout = 0;
    opcode = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic bus_chk(input string tag, input logic [31:0] exp);
    #1;
    check(tag, {32'h0, o_bus}, {32'h0, exp});
  endtask

  task automatic mdr_load(input logic [31:0] v);
    Mdatain = v; Read = 1; MDRin = 1;
    tick();
  endtask

  task automatic to_reg(input int idx, input logic [31:0] v);
    mdr_load(v);
    MDRout = 1; Rin[idx] = 1;
    tick();
  endtask

  task automatic to_y(input logic [31:0] v);
    mdr_load(v);
    MDRout = 1; Yin = 1;
    tick();
  endtask

  task automatic alu_op(input logic [4:0] op, input logic [31:0] b);
    mdr_load(b);
    MDRout = 1; Zin = 1; opcode = op;
    tick();
  endtask

  initial begin
    idle();
    clear = 0;

    // reset holds everything at 0 even with enables active
    Mdatain = 32'hFF; Read = 1; MDRin = 1; PCin = 1; IncPC = 1; Zin = 1; Yin = 1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_mdr", {32'h0, o_mdr}, 64'h0);
    check("rst_pc",  {32'h0, o_pc},  64'h0);
    check("rst_z",   o_z,            64'h0);
    idle();
    Rout[0] = 1;
    bus_chk("rst_bus_r0", 32'h0);
    idle();
    bus_chk("rst_bus_none", 32'h0);
    clear = 1;
    tick();
    check("post_rst_hold", {32'h0, o_pc}, 64'h0);

    // register loads through MDR
    to_reg(6, 32'h12);
    to_reg(7, 32'h14);
    Rout[6] = 1; bus_chk("r6", 32'h12); idle();
    Rout[7] = 1; bus_chk("r7", 32'h14); idle();
    Rout = 16'h00C0; bus_chk("prio_r6_r7", 32'h12); idle();

    // multiply 18 * 20
    Rout[6] = 1; Yin = 1; tick();
    Rout[7] = 1; Zin = 1; opcode = OP_MUL; tick();
    check("mul_z", o_z, 64'h168);
    Zlowout = 1; LOin = 1; tick();
    Zhighout = 1; HIin = 1; tick();
    check("mul_lo", {32'h0, o_lo}, 64'h168);
    check("mul_hi", {32'h0, o_hi}, 64'h0);
    Rout[7] = 1; HIout = 1; bus_chk("prio_r7_hi", 32'h14); idle();

    // multiply -2 * 3
    to_y(32'hFFFFFFFE);
    alu_op(OP_MUL, 32'd3);
    Zlowout = 1; LOin = 1; tick();
    Zhighout = 1; HIin = 1; tick();
    check("mul_neg_lo", {32'h0, o_lo}, 64'hFFFFFFFA);
    check("mul_neg_hi", {32'h0, o_hi}, 64'hFFFFFFFF);
    HIout = 1; LOout = 1; bus_chk("prio_hi_lo", 32'hFFFFFFFF); idle();
    LOout = 1; Zhighout = 1; bus_chk("prio_lo_zhi", 32'hFFFFFFFA); idle();
    Zlowout = 1; PCout = 1; bus_chk("prio_zlo_pc", 32'hFFFFFFFA); idle();

    // PC increment
    PCout = 1; MARin = 1; IncPC = 1; tick();
    check("pc_mar", {32'h0, o_mar}, 64'h0);
    check("pc_noinc", {32'h0, o_pc}, 64'h0);
    PCin = 1; IncPC = 1; tick();
    check("pc_inc", {32'h0, o_pc}, 64'h1);
    PCout = 1; PCin = 1; IncPC = 1; bus_chk("pc_old_on_bus", 32'h1); tick();
    check("pc_inc2", {32'h0, o_pc}, 64'h2);
    PCout = 1; MDRout = 1; bus_chk("prio_pc_mdr", 32'h2); idle();
    PCout = 1; PCin = 1; Zlowout = 1; tick();
    check("pc_from_bus", {32'h0, o_pc}, 64'hFFFFFFFA);

    // instruction fetch and constant
    mdr_load(32'h28918000);
    MDRout = 1; IRin = 1; tick();
    check("ir", {32'h0, o_ir}, 64'h28918000);
    Cout = 1; bus_chk("cout_pos", 32'h00018000); idle();
    Cout = 1; MDRout = 1; bus_chk("prio_mdr_c", 32'h28918000); idle();
    mdr_load(32'h00040005);
    MDRout = 1; IRin = 1; tick();
    Cout = 1; bus_chk("cout_neg", 32'hFFFC0005); idle();

    // ALU sweep, Y = 0x80000010, B = 4
    to_y(32'h80000010);
    alu_op(OP_ADD,  32'd4); check("add",  o_z, 64'h80000014);
    alu_op(OP_SUB,  32'd4); check("sub",  o_z, 64'h8000000C);
    alu_op(OP_AND,  32'd4); check("and",  o_z, 64'h0);
    alu_op(OP_OR,   32'd4); check("or",   o_z, 64'h80000014);
    alu_op(OP_SHR,  32'd4); check("shr",  o_z, 64'h08000001);
    alu_op(OP_SHRA, 32'd4); check("shra", o_z, 64'hF8000001);
    alu_op(OP_SHL,  32'd4); check("shl",  o_z, 64'h00000100);
    alu_op(OP_ROR,  32'd4); check("ror",  o_z, 64'h08000001);
    alu_op(OP_ROL,  32'd4); check("rol",  o_z, 64'h00000108);
    alu_op(OP_NEG,  32'd4); check("neg",  o_z, 64'hFFFFFFFC);
    alu_op(OP_NOT,  32'd4); check("not",  o_z, 64'hFFFFFFFB);
    alu_op(5'b11111, 32'd4); check("op_default", o_z, 64'h4);
    alu_op(OP_SHR,  32'd36); check("shr_amt36", o_z, 64'h08000001);
    alu_op(OP_ROR,  32'd32); check("ror_amt32", o_z, 64'h80000010);
    alu_op(OP_DIV,  32'd0);  check("div_zero", o_z, 64'h80000010_FFFFFFFF);

    // signed division
    to_y(32'd17);
    alu_op(OP_DIV, 32'hFFFFFFFB); check("div_17_m5", o_z, 64'h00000002_FFFFFFFD);
    to_y(32'hFFFFFFEF);
    alu_op(OP_DIV, 32'd5);        check("div_m17_5", o_z, 64'hFFFFFFFE_FFFFFFFD);

    // async reset mid-operation, then loads resume
    to_reg(5, 32'hAB);
    Rout[5] = 1; MDRin = 1; Read = 1; Mdatain = 32'h77;
    #2;
    clear = 0;
    #1;
    check("amid_mdr", {32'h0, o_mdr}, 64'h0);
    check("amid_z",   o_z,            64'h0);
    check("amid_bus_r5", {32'h0, o_bus}, 64'h0);
    idle();
    @(negedge clock);
    clear = 1;
    mdr_load(32'h55);
    check("resume_mdr", {32'h0, o_mdr}, 64'h55);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
